fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the `cpu` control FSM. Holds the program counter and reads 16-bit instructions from a synchronous instruction ROM. Presents each instruction on `inst` and pulses `run`, then holds it stable until `cpu` reports `done`. Resolves format-2'b10 branches against the ALU compare flag and updates the PC before the next fetch.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/branch_resolver.sv | 38 +++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the cpu control FSM.
//   - instruction format codes carried in inst[1:0]
//   - branch condition codes carried in inst[3:2] and on cmp_flag
//   - fetch sequencer state encoding
package cpu_pkg;

   localparam logic [1:0] FMT_REG = 2'b00;
   localparam logic [1:0] FMT_IMM = 2'b01;
   localparam logic [1:0] FMT_BR  = 2'b10;

   localparam logic [1:0] COND_EQ   = 2'b00;
   localparam logic [1:0] COND_GT   = 2'b01;
   localparam logic [1:0] COND_LT   = 2'b10;
   // cmp_flag value meaning "no compare result"; never satisfies a branch
   localparam logic [1:0] COND_NONE = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      ISSUE,
      WAIT_DONE
   } fetch_state_t;

endpackage

// File: rtl/branch_resolver.sv
// branch_resolver: combinational next-PC computation.
// Ports:
//   pc       in  ADDR_W : current program counter
//   inst     in  INST_W : instruction being completed
//   cmp_flag in  2      : ALU compare result sampled in the done cycle
//   next_pc  out ADDR_W : branch target when taken, else pc+1 (wrapping)
module branch_resolver
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int INST_W = 16
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [INST_W-1:0] inst,
   input  logic [1:0]        cmp_flag,
   output logic [ADDR_W-1:0] next_pc
);

   localparam logic [ADDR_W-1:0] PC_ONE = 1;

   logic [1:0]        cond;
   logic [ADDR_W-1:0] target;
   logic              taken;
   logic              unused_inst;

   assign cond   = inst[3:2];
   assign target = inst[ADDR_W+3:4];

   // A branch whose condition field is "none" can never match, even
   // though cmp_flag may also read "none".
   assign taken  = (inst[1:0] == FMT_BR) && (cond != COND_NONE) && (cond == cmp_flag);

   assign next_pc = taken ? target : (pc + PC_ONE);

   // Upper opcode bits are decoded by cpu, not here.
   assign unused_inst = ^inst;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the cpu control FSM.
// Holds the PC, reads the synchronous instruction ROM, presents the
// instruction on inst with a one-cycle run pulse and holds it until cpu
// signals done, then advances the PC.
// Optional feature macro: FETCH_BRANCH_EN (branch resolution on format
// 2'b10 against cmp_flag; without it every instruction advances to pc+1).
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   start                : begin execution at pc (IDLE only)
//   stop                 : finish current instruction, then go IDLE
//   mem_addr, mem_en     : ROM read address and strobe
//   mem_rdata            : ROM data, valid the cycle after mem_en
//   inst, run            : instruction and start pulse to cpu
//   done                 : cpu completion (its S2)
//   cmp_flag             : last ALU compare result
//   pc, busy             : program counter and not-IDLE status
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int INST_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   input  logic [INST_W-1:0] mem_rdata,
   output logic [INST_W-1:0] inst,
   output logic              run,
   input  logic              done,
   input  logic [1:0]        cmp_flag,
   output logic [ADDR_W-1:0] pc,
   output logic              busy
);

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] next_pc;

`ifdef FETCH_BRANCH_EN
   branch_resolver #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_branch_resolver (
      .pc       (pc),
      .inst     (inst),
      .cmp_flag (cmp_flag),
      .next_pc  (next_pc)
   );
`else
   localparam logic [ADDR_W-1:0] PC_ONE = 1;
   logic unused_cmp_flag;

   assign next_pc         = pc + PC_ONE;
   assign unused_cmp_flag = ^cmp_flag;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs decode from state only so nothing follows done combinationally.
   always_comb begin
      state_next = state;
      mem_en     = 1'b0;
      mem_addr   = '0;
      run        = 1'b0;
      busy       = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            mem_en     = 1'b1;
            mem_addr   = pc;
            state_next = LOAD;
         end
         LOAD: begin
            state_next = ISSUE;
         end
         ISSUE: begin
            run        = 1'b1;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done) begin
               state_next = stop ? IDLE : FETCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // inst only loads in LOAD, so it is stable from ISSUE through done;
   // pc only moves on the done edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc   <= '0;
         inst <= '0;
      end else begin
         if (state == LOAD) begin
            inst <= mem_rdata;
         end
         if ((state == WAIT_DONE) && done) begin
            pc <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a ROM
// model and a three-state cpu model (S0 -> S1 on run, S1 -> S2, done in S2).
module tb_fetch_unit;

   localparam int ADDR_W = 8;
   localparam int INST_W = 16;

`ifdef FETCH_BRANCH_EN
   localparam logic [7:0] EXP_BR_EQ = 8'h29;
`else
   localparam logic [7:0] EXP_BR_EQ = 8'h04;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_en;
   logic [INST_W-1:0] mem_rdata = '0;
   logic [INST_W-1:0] inst;
   logic              run;
   logic              done;
   logic [1:0]        cmp_flag = 2'b11;
   logic [ADDR_W-1:0] pc;
   logic              busy;

   logic [15:0] rom [0:255];
   logic [1:0]  cpu_s = 2'd0;
   logic        force_done = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .mem_addr  (mem_addr),
      .mem_en    (mem_en),
      .mem_rdata (mem_rdata),
      .inst      (inst),
      .run       (run),
      .done      (done),
      .cmp_flag  (cmp_flag),
      .pc        (pc),
      .busy      (busy)
   );

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= rom[mem_addr];
   end

   always @(posedge clk) begin
      if (reset) cpu_s <= 2'd0;
      else begin
         case (cpu_s)
            2'd0:    if (run) cpu_s <= 2'd1;
            2'd1:    cpu_s <= 2'd2;
            default: cpu_s <= 2'd0;
         endcase
      end
   end

   assign done = (cpu_s == 2'd2) | force_done;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From a FETCH cycle, run one full instruction; returns in the next FETCH.
   task automatic run_inst(input logic [1:0] cf);
      cmp_flag = cf;
      repeat (5) tick();
   endtask

   task automatic reset_and_start();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h want=00", pc); end
      checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL reset_inst got=%h want=0000", inst); end
      checks++; if (run !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 8'h00) begin
         errors++; $display("FAIL reset_outs run=%b mem_en=%b mem_addr=%h want 0/0/00", run, mem_en, mem_addr);
      end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold busy=%b want=0", busy); end
   endtask

   task automatic test_basic();
      start = 1'b1;
      tick();
      start = 1'b0;
      // C0
      checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin
         errors++; $display("FAIL c0_fetch mem_en=%b mem_addr=%h busy=%b want 1/00/1", mem_en, mem_addr, busy);
      end
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL c0_run got=%b want=0", run); end
      tick(); // C1
      checks++; if (run !== 1'b0 || mem_en !== 1'b0) begin
         errors++; $display("FAIL c1_load run=%b mem_en=%b want 0/0", run, mem_en);
      end
      tick(); // C2
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL c2_run got=%b want=1", run); end
      checks++; if (inst !== 16'h2005) begin errors++; $display("FAIL c2_inst got=%h want=2005", inst); end
      tick(); // C3
      checks++; if (run !== 1'b0 || inst !== 16'h2005 || pc !== 8'h00) begin
         errors++; $display("FAIL c3_wait run=%b inst=%h pc=%h want 0/2005/00", run, inst, pc);
      end
      tick(); // C4
      checks++; if (run !== 1'b0 || inst !== 16'h2005 || pc !== 8'h00) begin
         errors++; $display("FAIL c4_done run=%b inst=%h pc=%h want 0/2005/00", run, inst, pc);
      end
      tick(); // C5
      checks++; if (pc !== 8'h01) begin errors++; $display("FAIL c5_pc got=%h want=01", pc); end
      checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h01) begin
         errors++; $display("FAIL c5_fetch mem_en=%b mem_addr=%h want 1/01", mem_en, mem_addr);
      end
   endtask

   task automatic test_branch();
      run_inst(2'b00);
      run_inst(2'b00);
      checks++; if (pc !== 8'h03) begin errors++; $display("FAIL br_reach3 got=%h want=03", pc); end
      cmp_flag = 2'b00;
      tick();
      tick();
      checks++; if (inst !== 16'h0292) begin errors++; $display("FAIL br_inst got=%h want=0292", inst); end
      repeat (3) tick();
      checks++; if (pc !== EXP_BR_EQ || mem_addr !== EXP_BR_EQ) begin
         errors++; $display("FAIL br_eq pc=%h mem_addr=%h want=%h", pc, mem_addr, EXP_BR_EQ);
      end
      reset_and_start();
      run_inst(2'b00);
      run_inst(2'b00);
      run_inst(2'b00);
      run_inst(2'b01);
      checks++; if (pc !== 8'h04) begin errors++; $display("FAIL br_ne pc=%h want=04", pc); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 300 && pc != 8'hFF; i++) run_inst(2'b00);
      checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_reach got=%h want=ff", pc); end
      run_inst(2'b00);
      checks++; if (pc !== 8'h00 || mem_addr !== 8'h00 || mem_en !== 1'b1) begin
         errors++; $display("FAIL wrap_pc pc=%h mem_addr=%h mem_en=%b want 00/00/1", pc, mem_addr, mem_en);
      end
   endtask

   task automatic test_stop();
      tick();
      tick();
      tick(); // C3
      stop = 1'b1;
      tick(); // C4
      tick();
      checks++; if (busy !== 1'b0 || pc !== 8'h01 || mem_en !== 1'b0) begin
         errors++; $display("FAIL stop_idle busy=%b pc=%h mem_en=%b want 0/01/0", busy, pc, mem_en);
      end
      tick();
      tick();
      checks++; if (busy !== 1'b0 || mem_en !== 1'b0 || pc !== 8'h01) begin
         errors++; $display("FAIL stop_hold busy=%b mem_en=%b pc=%h want 0/0/01", busy, mem_en, pc);
      end
      stop = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h01) begin
         errors++; $display("FAIL stop_resume mem_en=%b mem_addr=%h want 1/01", mem_en, mem_addr);
      end
   endtask

   task automatic test_ignore();
      tick(); // LOAD
      start = 1'b1;
      force_done = 1'b1;
      tick(); // ISSUE
      start = 1'b0;
      force_done = 1'b0;
      checks++; if (run !== 1'b1 || pc !== 8'h01) begin
         errors++; $display("FAIL ign_issue run=%b pc=%h want 1/01", run, pc);
      end
      tick(); // C3
      checks++; if (run !== 1'b0 || pc !== 8'h01) begin
         errors++; $display("FAIL ign_c3 run=%b pc=%h want 0/01", run, pc);
      end
      tick(); // C4
      checks++; if (run !== 1'b0 || pc !== 8'h01) begin
         errors++; $display("FAIL ign_c4 run=%b pc=%h want 0/01", run, pc);
      end
      tick();
      checks++; if (pc !== 8'h02 || mem_addr !== 8'h02) begin
         errors++; $display("FAIL ign_next pc=%h mem_addr=%h want 02/02", pc, mem_addr);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      tick();
      tick(); // C3, WAIT_DONE
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || pc !== 8'h00 || inst !== 16'h0000 || run !== 1'b0) begin
         errors++; $display("FAIL rst_mid busy=%b pc=%h inst=%h run=%b want 0/00/0000/0", busy, pc, inst, run);
      end
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      tick();
      checks++; if (pc !== 8'h00 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_spurious pc=%h busy=%b want 00/0", pc, busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h0001;
      rom[0]    = 16'h2005;
      rom[3]    = 16'h0292;
      rom[8'h29] = 16'h0FF2;
      rom[8'hFF] = 16'h0001;
      test_reset();
      test_basic();
      test_branch();
      test_wrap();
      test_stop();
      test_ignore();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
